// File: rtl/camera_capture_if.sv
// rtl/camera_capture_if.sv - camera parallel bus and captured pixel stream
interface camera_capture_if;
    logic        cam_pclk_i;
    logic        cam_vsync_i;
    logic        cam_href_i;
    logic [7:0]  cam_data_i;
    logic [15:0] pixel_o;
    logic        pixel_valid_o;
    logic [9:0]  x_o;
    logic [8:0]  y_o;
    logic        frame_start_o;
    logic        frame_done_o;
    logic        busy_o;

    // Camera / consumer side: drives the sensor bus, observes captured pixels.
    modport master (
        output cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i,
        input  pixel_o, pixel_valid_o, x_o, y_o, frame_start_o, frame_done_o, busy_o
    );

    // Capture block side.
    modport slave (
        input  cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i,
        output pixel_o, pixel_valid_o, x_o, y_o, frame_start_o, frame_done_o, busy_o
    );
endinterface

// File: rtl/camera_capture.sv
// rtl/camera_capture.sv - oversampled OV7670 parallel capture to RGB565 pixels
module camera_capture #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               setup_done_i,
    camera_capture_if.slave    cam
);

    typedef enum logic [1:0] {
        WAIT_SETUP,
        WAIT_VSYNC,
        FRAME
    } state_t;

    localparam logic [9:0] X_LIM = 10'(H_RES);
    localparam logic [8:0] Y_LIM = 9'(V_RES);

    logic [SYNC_STAGES-1:0] pclk_sync;
    logic [SYNC_STAGES-1:0] vsync_sync;
    logic [SYNC_STAGES-1:0] href_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   pclk_prev;
    logic                   vsync_prev;
    logic                   href_prev;

    state_t     state;
    logic       phase;
    logic [7:0] hi_byte;
    logic [9:0] x_cnt;
    logic [8:0] line_cnt;

    logic       pclk_s, vsync_s, href_s;
    logic [7:0] data_s;
    logic       pclk_rise, vsync_rise, vsync_fall, href_fall;
    logic       byte_take, pix_done, pix_keep;
    logic [9:0] x_after;

    // Bring every camera input across with identical latency, plus one extra
    // flop on the control lines for edge detection.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pclk_sync  <= '0;
            vsync_sync <= '0;
            href_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
            pclk_prev  <= 1'b0;
            vsync_prev <= 1'b0;
            href_prev  <= 1'b0;
        end else begin
            pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], cam.cam_pclk_i};
            vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], cam.cam_vsync_i};
            href_sync  <= {href_sync[SYNC_STAGES-2:0], cam.cam_href_i};
            data_sync[0] <= cam.cam_data_i;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            pclk_prev  <= pclk_sync[SYNC_STAGES-1];
            vsync_prev <= vsync_sync[SYNC_STAGES-1];
            href_prev  <= href_sync[SYNC_STAGES-1];
        end
    end

    assign pclk_s  = pclk_sync[SYNC_STAGES-1];
    assign vsync_s = vsync_sync[SYNC_STAGES-1];
    assign href_s  = href_sync[SYNC_STAGES-1];
    assign data_s  = data_sync[SYNC_STAGES-1];

    assign pclk_rise  = pclk_s & ~pclk_prev;
    assign vsync_rise = vsync_s & ~vsync_prev;
    assign vsync_fall = ~vsync_s & vsync_prev;
    assign href_fall  = ~href_s & href_prev;

    // A byte still counts when its PCLK edge lands together with HREF falling,
    // so the line's final pixel completes before the counters are cleared.
    assign byte_take = pclk_rise & (href_s | href_prev);
    assign pix_done  = byte_take & phase;
    assign pix_keep  = pix_done & (x_cnt < X_LIM) & (line_cnt < Y_LIM);
    assign x_after   = (pix_done && (x_cnt < X_LIM)) ? x_cnt + 10'd1 : x_cnt;

    // Frame sequencing, byte assembly and coordinate counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state             <= WAIT_SETUP;
            phase             <= 1'b0;
            hi_byte           <= '0;
            x_cnt             <= '0;
            line_cnt          <= '0;
            cam.pixel_o       <= '0;
            cam.pixel_valid_o <= 1'b0;
            cam.x_o           <= '0;
            cam.y_o           <= '0;
            cam.frame_start_o <= 1'b0;
            cam.frame_done_o  <= 1'b0;
            cam.busy_o        <= 1'b0;
        end else begin
            cam.pixel_valid_o <= 1'b0;
            cam.frame_start_o <= 1'b0;
            cam.frame_done_o  <= 1'b0;
            if (!setup_done_i) begin
                state      <= WAIT_SETUP;
                cam.busy_o <= 1'b0;
            end else begin
                case (state)
                    WAIT_SETUP: state <= WAIT_VSYNC;
                    WAIT_VSYNC: begin
                        if (vsync_fall) begin
                            state             <= FRAME;
                            cam.busy_o        <= 1'b1;
                            cam.frame_start_o <= 1'b1;
                            x_cnt             <= '0;
                            line_cnt          <= '0;
                            phase             <= 1'b0;
                        end
                    end
                    FRAME: begin
                        if (vsync_rise) begin
                            state            <= WAIT_VSYNC;
                            cam.busy_o       <= 1'b0;
                            cam.frame_done_o <= 1'b1;
                        end else begin
                            if (byte_take) begin
                                phase <= ~phase;
                                if (!phase) hi_byte <= data_s;
                            end
                            if (pix_keep) begin
                                cam.pixel_o       <= {hi_byte, data_s};
                                cam.x_o           <= x_cnt;
                                cam.y_o           <= line_cnt;
                                cam.pixel_valid_o <= 1'b1;
                            end
                            x_cnt <= x_after;
                            if (href_fall) begin
                                x_cnt <= '0;
                                phase <= 1'b0;
                                if (x_after != 10'd0 && line_cnt < Y_LIM)
                                    line_cnt <= line_cnt + 9'd1;
                            end
                        end
                    end
                    default: state <= WAIT_SETUP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// tb/tb_camera_capture.sv - self-checking bench for camera_capture
module tb_camera_capture;

    localparam int H_RES = 4;
    localparam int V_RES = 2;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + 1;
    localparam int NCYC  = 8192;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic setup_done_i = 1'b0;

    camera_capture_if cam_if();

    camera_capture #(
        .H_RES(H_RES),
        .V_RES(V_RES),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .setup_done_i(setup_done_i),
        .cam(cam_if.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output events, indexed by the cycle they must be visible in.
    bit          exp_valid [NCYC];
    logic [15:0] exp_pix   [NCYC];
    logic [9:0]  exp_x     [NCYC];
    logic [8:0]  exp_y     [NCYC];
    bit          exp_fs    [NCYC];
    bit          exp_fd    [NCYC];
    bit          busy_set  [NCYC];
    bit          busy_clr  [NCYC];

    int checks = 0;
    int passes = 0;

    // Frame-level model state.
    bit         model_en  = 1'b0;
    bit         capturing = 1'b0;
    int         line_idx  = 0;
    logic [7:0] dv = 8'h11;

    // Observations gathered by the compare process.
    int          n_valid = 0, n_fs = 0, n_fd = 0;
    logic [15:0] first_pix = '0, last_pix = '0;
    logic [9:0]  last_x = '0, max_x = '0;
    logic [8:0]  last_y = '0, max_y = '0;
    bit          first_pend = 1'b0;
    bit          busy_m = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: every cycle, control outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            begin
                int c;
                c = cyc;
                if (c < NCYC) begin
                    if (busy_set[c]) busy_m = 1'b1;
                    if (busy_clr[c]) busy_m = 1'b0;
                    check("ctrl", 64'({cam_if.pixel_valid_o, cam_if.frame_start_o,
                                       cam_if.frame_done_o, cam_if.busy_o}),
                                  64'({exp_valid[c], exp_fs[c], exp_fd[c], busy_m}));
                    if (exp_valid[c] && cam_if.pixel_valid_o)
                        check("pixel", 64'({cam_if.pixel_o, cam_if.x_o, cam_if.y_o}),
                                       64'({exp_pix[c], exp_x[c], exp_y[c]}));
                end
                if (cam_if.frame_start_o) begin
                    n_fs++;
                    first_pend = 1'b1;
                end
                if (cam_if.frame_done_o) n_fd++;
                if (cam_if.pixel_valid_o) begin
                    n_valid++;
                    if (first_pend) begin
                        first_pix  = cam_if.pixel_o;
                        first_pend = 1'b0;
                    end
                    last_pix = cam_if.pixel_o;
                    last_x   = cam_if.x_o;
                    last_y   = cam_if.y_o;
                    if (cam_if.x_o > max_x) max_x = cam_if.x_o;
                    if (cam_if.y_o > max_y) max_y = cam_if.y_o;
                end
            end
        end
    end

    task automatic frame_begin();
        cam_if.cam_vsync_i = 1'b1;
        tick(8);
        cam_if.cam_vsync_i = 1'b0;
        if (model_en && !capturing && cyc + LAT < NCYC) begin
            exp_fs[cyc + LAT]   = 1'b1;
            busy_set[cyc + LAT] = 1'b1;
            capturing = 1'b1;
            line_idx  = 0;
        end
        dv = 8'h11;
        tick(8);
    endtask

    task automatic frame_end();
        cam_if.cam_vsync_i = 1'b1;
        if (capturing && cyc + LAT < NCYC) begin
            exp_fd[cyc + LAT]   = 1'b1;
            busy_clr[cyc + LAT] = 1'b1;
            capturing = 1'b0;
        end
        tick(8);
    endtask

    // One HREF line of nbytes bytes, PCLK = 8 system clocks. Pixel k of the
    // line is bytes 2k,2k+1; it is kept only inside the H_RES x V_RES window.
    task automatic send_line(input int nbytes, input bit coincident_end);
        logic [7:0] hi;
        hi = '0;
        cam_if.cam_href_i = 1'b1;
        tick(4);
        for (int k = 0; k < nbytes; k++) begin
            cam_if.cam_pclk_i = 1'b0;
            cam_if.cam_data_i = dv;
            tick(4);
            cam_if.cam_pclk_i = 1'b1;
            if (coincident_end && k == nbytes - 1) cam_if.cam_href_i = 1'b0;
            if (k % 2 == 0) hi = dv;
            else if (capturing && (k / 2) < H_RES && line_idx < V_RES && cyc + LAT < NCYC) begin
                exp_valid[cyc + LAT] = 1'b1;
                exp_pix[cyc + LAT]   = {hi, dv};
                exp_x[cyc + LAT]     = 10'(k / 2);
                exp_y[cyc + LAT]     = 9'(line_idx);
            end
            dv = dv + 8'h11;
            tick(4);
        end
        cam_if.cam_pclk_i = 1'b0;
        tick(4);
        cam_if.cam_href_i = 1'b0;
        tick(8);
        if (capturing && nbytes >= 2 && line_idx < V_RES) line_idx++;
    endtask

    task automatic set_setup(input bit en);
        setup_done_i = en;
        model_en = en;
        if (!en && capturing && cyc + 1 < NCYC) begin
            busy_clr[cyc + 1] = 1'b1;
            capturing = 1'b0;
        end
    endtask

    int b_v, b_fs, b_fd;

    initial begin
        cam_if.cam_pclk_i  = 1'b0;
        cam_if.cam_vsync_i = 1'b1;
        cam_if.cam_href_i  = 1'b0;
        cam_if.cam_data_i  = '0;

        // Reset held while the camera bus toggles.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cam_if.cam_pclk_i  = ~cam_if.cam_pclk_i;
            cam_if.cam_vsync_i = 1'($urandom_range(0, 1));
            cam_if.cam_href_i  = 1'($urandom_range(0, 1));
            cam_if.cam_data_i  = 8'($urandom_range(0, 255));
        end
        check("reset_outputs", 64'({cam_if.pixel_o, cam_if.x_o, cam_if.y_o, cam_if.pixel_valid_o,
                                    cam_if.frame_start_o, cam_if.frame_done_o, cam_if.busy_o}), 64'd0);

        // Out of reset but not enabled: the bus keeps toggling, nothing happens.
        rst_i = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (i % 4 == 0) cam_if.cam_pclk_i = ~cam_if.cam_pclk_i;
            if (i % 12 == 0) cam_if.cam_vsync_i = ~cam_if.cam_vsync_i;
            cam_if.cam_href_i = 1'($urandom_range(0, 1));
            cam_if.cam_data_i = 8'($urandom_range(0, 255));
        end
        cam_if.cam_pclk_i  = 1'b0;
        cam_if.cam_href_i  = 1'b0;
        cam_if.cam_vsync_i = 1'b1;
        tick(8);
        check("idle_outputs", 64'({cam_if.pixel_o, cam_if.x_o, cam_if.y_o, cam_if.busy_o}), 64'd0);
        check("idle_no_pixels", 64'(n_valid), 64'd0);

        // Small frame: 2 lines of 4 pixels.
        set_setup(1'b1);
        tick(4);
        b_v = n_valid; b_fs = n_fs; b_fd = n_fd;
        frame_begin();
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        frame_end();
        tick(LAT + 4);
        check("small_npix", 64'(n_valid - b_v), 64'd8);
        check("small_first", 64'(first_pix), 64'h1122);
        check("small_last_pix", 64'(last_pix), 64'hFF10);
        check("small_last_xy", 64'({last_x, last_y}), 64'({10'd3, 9'd1}));
        check("small_fs", 64'(n_fs - b_fs), 64'd1);
        check("small_fd", 64'(n_fd - b_fd), 64'd1);

        // Overflow: 3 lines of 6 pixels in a 4x2 window.
        b_v = n_valid;
        frame_begin();
        for (int l = 0; l < 3; l++) send_line(12, 1'b0);
        frame_end();
        tick(LAT + 4);
        check("ovf_npix", 64'(n_valid - b_v), 64'd8);
        check("ovf_max_x", 64'(max_x), 64'd3);
        check("ovf_max_y", 64'(max_y), 64'd1);

        // Odd byte count, then a line whose last PCLK edge coincides with HREF fall.
        b_v = n_valid;
        frame_begin();
        send_line(9, 1'b0);
        send_line(8, 1'b1);
        frame_end();
        tick(LAT + 4);
        check("odd_npix", 64'(n_valid - b_v), 64'd8);
        check("odd_last_xy", 64'({last_x, last_y}), 64'({10'd3, 9'd1}));

        // Enable in the middle of a frame: nothing until the next VSYNC fall.
        set_setup(1'b0);
        tick(4);
        b_v = n_valid; b_fs = n_fs; b_fd = n_fd;
        frame_begin();
        send_line(8, 1'b0);
        set_setup(1'b1);
        send_line(8, 1'b0);
        frame_end();
        check("mid_no_pix", 64'(n_valid - b_v), 64'd0);
        frame_begin();
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        frame_end();
        tick(LAT + 4);
        check("mid_npix", 64'(n_valid - b_v), 64'd8);
        check("mid_fs", 64'(n_fs - b_fs), 64'd1);
        check("mid_fd", 64'(n_fd - b_fd), 64'd1);

        // Abort after 2 lines, then re-enable mid-frame.
        b_fd = n_fd;
        frame_begin();
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        set_setup(1'b0);
        tick(4);
        check("abort_busy", 64'(cam_if.busy_o), 64'd0);
        set_setup(1'b1);
        b_v = n_valid;
        send_line(8, 1'b0);
        frame_end();
        tick(LAT + 4);
        check("abort_no_fd", 64'(n_fd - b_fd), 64'd0);
        check("abort_no_pix", 64'(n_valid - b_v), 64'd0);
        frame_begin();
        send_line(8, 1'b0);
        frame_end();
        tick(LAT + 4);
        check("reenable_npix", 64'(n_valid - b_v), 64'd4);
        check("reenable_fd", 64'(n_fd - b_fd), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/camera_capture.md
Name: camera_capture

Overview:
- Pixel capture stage directly downstream of the OV7670 camera setup block.
- Enabled once setup reports done. Oversamples the camera's parallel bus (PCLK, VSYNC, HREF, D[7:0]) in the system clock domain.
- Assembles RGB565 pixels from byte pairs and emits them with X/Y coordinates and frame markers for the frame buffer writer.

Parameters:
- H_RES, 640, active pixels per line; pixels beyond this count are dropped.
- V_RES, 480, active lines per frame; lines beyond this count are dropped.
- SYNC_STAGES, 2, synchronizer flops on every camera input (minimum 2).

Ports:
- clk_i  in  1  system clock; must be at least 4x cam_pclk_i frequency.
- rst_i  in  1  synchronous reset, active low (0 = reset).
- setup_done_i  in  1  camera setup complete; capture is gated by it.
- cam_pclk_i  in  1  camera pixel clock, asynchronous.
- cam_vsync_i  in  1  camera VSYNC; high = vertical blanking.
- cam_href_i  in  1  camera HREF; high = active line data.
- cam_data_i  in  8  camera data bus; changes on PCLK falling edge.
- pixel_o  out  16  RGB565 pixel, {first byte, second byte}.
- pixel_valid_o  out  1  one-clk_i strobe; pixel_o, x_o and y_o are valid.
- x_o  out  10  column of the current pixel_o, range 0..H_RES-1.
- y_o  out  9  row of the current pixel_o, range 0..V_RES-1.
- frame_start_o  out  1  one-clk_i pulse on VSYNC falling edge (frame begins).
- frame_done_o  out  1  one-clk_i pulse on VSYNC rising edge after a captured frame.
- busy_o  out  1  high while in the FRAME state.

Behaviour:
- Reset (rst_i=0 sampled on a clk_i rising edge):
  - All outputs go to 0, synchronizers clear, state goes to WAIT_SETUP.
  - Applies equally mid-frame; the partial frame is discarded with no frame_done_o.
- Synchronization:
  - pclk, vsync, href and data each pass through SYNC_STAGES flops; all share identical latency.
  - One extra flop on pclk/vsync/href feeds edge detection.
  - pclk_rise = s_last & ~s_prev; vsync_rise and vsync_fall are defined the same way; href_fall = ~s_last & s_prev.
- FSM states: WAIT_SETUP, WAIT_VSYNC, FRAME.
  - WAIT_SETUP -> WAIT_VSYNC when setup_done_i=1.
  - WAIT_VSYNC: ignores everything except vsync_fall. On vsync_fall: -> FRAME, pulse frame_start_o, clear x/y counters and the byte phase.
  - FRAME -> WAIT_VSYNC on vsync_rise, pulsing frame_done_o in the same cycle.
  - Any state -> WAIT_SETUP on the next clk_i when setup_done_i=0, without frame_done_o.
  - The first frame after enable is never partial; the block waits for a full VSYNC falling edge.
- Byte assembly (FRAME only):
  - On pclk_rise with href=1: phase 0 latches data into the high byte, then phase becomes 1.
  - Phase 1 latches the low byte, then phase becomes 0 and a pixel is complete.
  - pixel_valid_o asserts on the clk_i cycle after the pclk_rise that completed the pixel, for exactly 1 cycle.
  - pixel_o, x_o and y_o hold their values until the next pixel.
- Counters:
  - x increments after each completed pixel.
  - Pixels with x >= H_RES or line >= V_RES are dropped: no valid strobe, and the x counter saturates at H_RES.
  - On href_fall: if x != 0, line increments, saturating at V_RES. x and phase always clear.
  - An odd byte count at href_fall discards the orphan byte.
- Simultaneous events:
  - vsync_rise wins over pclk_rise in the same cycle; the byte is ignored.
  - href_fall and a final pclk_rise in the same cycle: the pixel completes first, then the counters apply.
- Widths: x counter is 10 bits, line counter 9 bits. The defaults H_RES=640 and V_RES=480 fit, as do the saturation values.

Test Plan:
- Reset/enable: hold rst_i=0, toggle the camera bus, then release with setup_done_i=0. Required: all outputs stay 0, state stays WAIT_SETUP, no pixel_valid_o.
- Small frame (H_RES=4, V_RES=2), clk_i = 8x pclk, data bytes 0x11,0x22,0x33,0x44,... Required: frame_start_o once; 8 pixels, the first being 0x1122 at (0,0), with pixel_valid_o exactly 1 clk after the second byte's sync edge; the last pixel at (3,1); frame_done_o once on VSYNC rise.
- Overflow: a line of 6 pixels with H_RES=4, and 3 lines with V_RES=2. Required: only x=0..3 and y=0..1 strobe; x and y never exceed 3 and 1.
- Odd bytes: a line of 9 bytes. Required: 4 pixels, the orphan byte is discarded, and the next line starts at x=0 on phase 0.
- Mid-frame start: enable while VSYNC is low mid-frame. Required: no pixels until the next VSYNC fall, then a full frame.
- Abort: drop setup_done_i after 2 lines. Required: WAIT_SETUP, no frame_done_o, busy_o=0. Re-enabling waits for a new frame.
